regfile_32x32: RTL and testbench

Register file for the Datapath2 core: 32 registers of 32 bits, two asynchronous read ports and one synchronous write port. It sits directly downstream of the 5-to-32 one-hot write-address decoder, which turns the write address into per-register write strobes. Read data feeds the ALU operand muxes; write data comes from the write-back mux.

---
 rtl/dp2_pkg.sv | 11 +
 rtl/decoder.sv | 15 +
 rtl/regfile_32x32.sv | 76 +++++++
 tb/tb_regfile_32x32.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dp2_pkg.sv
// Shared Datapath2 definitions: register-file geometry and common types.
package dp2_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned WIDTH = 32;

  typedef logic [AW-1:0]    regaddr_t;
  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/decoder.sv
// 5-to-32 one-hot decoder: exactly one output bit set for every address.
module decoder
  import dp2_pkg::*;
(
  input  regaddr_t           a,
  output logic [NREGS-1:0]   y
);

  // One-hot expansion of the address.
  always_comb begin
    y    = '0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/regfile_32x32.sv
// 32-entry register file: two combinational read ports, one write port,
// optional same-cycle write forwarding, r0 hardwired to zero, and a
// saturating count of committed writes.
module regfile_32x32 #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [15:0]      wr_cnt
);

  import dp2_pkg::*;

  logic [NREGS-1:0] onehot;
  logic [NREGS-1:0] we_vec;
  logic             wr_hit;
  logic [WIDTH-1:0] regs_q [1:NREGS-1];
  logic [WIDTH-1:0] rf     [NREGS];
  logic [15:0]      wr_cnt_q;
  logic             unused_we0;

  decoder u_decoder (
    .a (wa),
    .y (onehot)
  );

  assign we_vec     = we ? onehot : '0;
  // r0 has no storage, so its strobe goes nowhere.
  assign unused_we0 = we_vec[0];
  assign wr_hit     = |we_vec[NREGS-1:1];

  // Storage for r1..r31; r0 deliberately has no flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (we_vec[i]) regs_q[i] <= wd;
      end
    end
  end

  // Flat read view with r0 tied to zero.
  always_comb begin
    rf[0] = '0;
    for (int i = 1; i < NREGS; i++) rf[i] = regs_q[i];
  end

  // Read muxes plus forwarding; a nonzero-address match is required so r0 stays zero.
  always_comb begin
    rd1 = rf[ra1];
    rd2 = rf[ra2];
    if (BYPASS && we && (wa != '0) && (wa == ra1)) rd1 = wd;
    if (BYPASS && we && (wa != '0) && (wa == ra2)) rd2 = wd;
  end

  // Saturating count of writes that actually land in a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
    end else if (wr_hit && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32: one forwarding and one
// non-forwarding instance driven by the same stimulus.
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [15:0] cnt_b, cnt_n;

  always #5 clk = ~clk;

  regfile_32x32 #(.WIDTH(32), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_b), .rd2(rd2_b), .wr_cnt(cnt_b)
  );

  regfile_32x32 #(.WIDTH(32), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_n), .rd2(rd2_n), .wr_cnt(cnt_n)
  );

  // An unknown write address with write enabled is illegal stimulus.
  always @(posedge clk) begin
    if (we === 1'b1) assert (!$isunknown(wa)) else $error("X on wa while we=1");
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;   // forwarding instance, before the edge
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] b1, b2, n1, n2;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [32];
  int unsigned mcnt;
  int          checks = 0;
  int          errors = 0;
  vec_t        tab [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && (wa == a)) return wd;
    return model[a];
  endfunction

  function automatic logic [31:0] plain_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    mcnt = 0;
  endtask

  // Drive one cycle, push expectations, compare before the edge, update the model.
  task automatic step(input vec_t v, input bit use_tab, input string tag);
    exp_t e, got;
    @(negedge clk);
    we = v.we; wa = v.wa; wd = v.wd; ra1 = v.ra1; ra2 = v.ra2;
    e.b1  = use_tab ? v.e1 : fwd_read(v.ra1);
    e.b2  = use_tab ? v.e2 : fwd_read(v.ra2);
    e.n1  = plain_read(v.ra1);
    e.n2  = plain_read(v.ra2);
    e.cnt = mcnt[15:0];
    sbq.push_back(e);
    #2;
    got = sbq.pop_front();
    chk({tag, " rd1 byp"}, rd1_b, got.b1);
    chk({tag, " rd2 byp"}, rd2_b, got.b2);
    chk({tag, " rd1 nobyp"}, rd1_n, got.n1);
    chk({tag, " rd2 nobyp"}, rd2_n, got.n2);
    chk({tag, " cnt byp"}, {16'h0, cnt_b}, {16'h0, got.cnt});
    chk({tag, " cnt nobyp"}, {16'h0, cnt_n}, {16'h0, got.cnt});
    if (v.we && (v.wa != 5'd0)) begin
      model[v.wa] = v.wd;
      if (mcnt != 32'hFFFF) mcnt++;
    end
  endtask

  initial begin
    vec_t v;
    tab[0]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd31, 32'h12345678, 32'h0};
    tab[1]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd7,  5'd31, 32'h12345678, 32'hFFFFFFFF};
    tab[2]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'h12345678, 32'hFFFFFFFF};
    tab[3]  = '{1'b1, 5'd0,  32'hAAAAAAAA, 5'd0,  5'd0,  32'h0,        32'h0};
    tab[4]  = '{1'b0, 5'd0,  32'hAAAAAAAA, 5'd0,  5'd7,  32'h0,        32'h12345678};
    tab[5]  = '{1'b1, 5'd3,  32'h1,        5'd3,  5'd9,  32'h1,        32'h0};
    tab[6]  = '{1'b1, 5'd9,  32'hBEEF,     5'd3,  5'd9,  32'h1,        32'hBEEF};
    tab[7]  = '{1'b1, 5'd3,  32'h55,       5'd3,  5'd3,  32'h55,       32'h55};
    tab[8]  = '{1'b0, 5'd9,  32'hCAFE,     5'd3,  5'd9,  32'h55,       32'hBEEF};
    tab[9]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd3,  32'hBEEF,     32'h55};
    tab[10] = '{1'b1, 5'd31, 32'h0F0F0F0F, 5'd31, 5'd7,  32'h0F0F0F0F, 32'h12345678};
    tab[11] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h0F0F0F0F, 32'h0F0F0F0F};

    rst = 1'b1; we = 1'b0; wa = 5'd0; wd = 32'h0; ra1 = 5'd5; ra2 = 5'd31;
    model_reset();
    #12;
    chk("reset rd1 byp", rd1_b, 32'h0);
    chk("reset rd2 byp", rd2_b, 32'h0);
    chk("reset rd1 nobyp", rd1_n, 32'h0);
    chk("reset cnt byp", {16'h0, cnt_b}, 32'h0);
    chk("reset cnt nobyp", {16'h0, cnt_n}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) step(tab[i], 1'b1, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a cycle.
    v = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'h0, 32'h0};
    step(v, 1'b0, "wr r5");
    @(negedge clk);
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    chk("r5 before reset", rd1_n, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("async rst rd1 byp", rd1_b, 32'h0);
    chk("async rst rd1 nobyp", rd1_n, 32'h0);
    chk("async rst cnt byp", {16'h0, cnt_b}, 32'h0);
    chk("async rst cnt nobyp", {16'h0, cnt_n}, 32'h0);
    model_reset();

    // Write presented during reset must be discarded.
    @(negedge clk);
    we = 1'b1; wa = 5'd4; wd = 32'h77; ra1 = 5'd4; ra2 = 5'd5;
    #1;
    chk("rst fwd rd1 byp", rd1_b, 32'h77);
    chk("rst fwd rd1 nobyp", rd1_n, 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    #1;
    chk("rst write dropped byp", rd1_b, 32'h0);
    chk("rst write dropped nobyp", rd1_n, 32'h0);
    chk("rst write uncounted", {16'h0, cnt_b}, 32'h0);

    // Counter saturation: continuous writes to r1.
    @(negedge clk);
    we = 1'b1; wa = 5'd1; wd = 32'h1; ra1 = 5'd1; ra2 = 5'd0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("cnt fffe byp", {16'h0, cnt_b}, 32'hFFFE);
    chk("cnt fffe nobyp", {16'h0, cnt_n}, 32'hFFFE);
    @(negedge clk);
    chk("cnt ffff byp", {16'h0, cnt_b}, 32'hFFFF);
    chk("cnt ffff nobyp", {16'h0, cnt_n}, 32'hFFFF);
    @(negedge clk);
    chk("cnt sat byp", {16'h0, cnt_b}, 32'hFFFF);
    chk("cnt sat nobyp", {16'h0, cnt_n}, 32'hFFFF);
    chk("r1 stored", rd1_n, 32'h1);
    we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
